// File: rtl/a2d_spi_resp_if.sv
// rtl/a2d_spi_resp_if.sv - SPI link between the pot-reading initiator and the A2D responder
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/a2d_spi_resp.sv
// rtl/a2d_spi_resp.sv - SPI responder emulating an 8-channel 12-bit A2D with pipelined channel select
module a2d_spi_resp #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  a2d_spi_resp_if.slave            spi,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [2:0]               cur_ch,
  output logic                     cmd_vld,
  output logic                     frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic ss_meta, ss_sync, ss_d;
  logic sclk_meta, sclk_sync, sclk_d;
  logic mosi_meta, mosi_sync;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [15:0] tx_shift, tx_nxt;
  // Only the last 14 received bits are kept: after 16 shifts bits [13:11]
  // still hold frame bits 2..4, and the two leading bits are never used.
  logic [13:0] rx_shift, rx_nxt;
  logic [2:0]  cur_ch_nxt;
  logic        cmd_pend, cmd_pend_nxt;
  logic        cmd_vld_nxt, frame_err_nxt;
  logic [DATA_W-1:0] sel_data;

  // Two-flop synchronizers plus a third flop for edge detection on SS_n/SCLK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_d      <= 1'b1;
      sclk_meta <= 1'b1;
      sclk_sync <= 1'b1;
      sclk_d    <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      ss_meta   <= spi.SS_n;
      ss_sync   <= ss_meta;
      ss_d      <= ss_sync;
      sclk_meta <= spi.SCLK;
      sclk_sync <= sclk_meta;
      sclk_d    <= sclk_sync;
      mosi_meta <= spi.MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  assign ss_fall   = ss_d & ~ss_sync;
  assign ss_rise   = ~ss_d & ss_sync;
  assign sclk_rise = ~sclk_d & sclk_sync;
  assign sclk_fall = sclk_d & ~sclk_sync;

  // Channel mux; addresses with no matching channel read as zero
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == 3'(k)) sel_data = ch_data[k*DATA_W +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath decisions for the frame protocol
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    tx_nxt        = tx_shift;
    rx_nxt        = rx_shift;
    cur_ch_nxt    = cur_ch;
    cmd_pend_nxt  = cmd_pend;
    cmd_vld_nxt   = 1'b0;
    frame_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (ss_fall) begin
          // Snapshot taken here; later ch_data changes do not affect this frame
          tx_nxt      = 16'(sel_data);
          bit_cnt_nxt = 5'd0;
          state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        if (sclk_rise && bit_cnt == 5'd15) begin
          // 16th edge completes the frame even if SS_n rises in the same clk
          rx_nxt       = {rx_shift[12:0], mosi_sync};
          bit_cnt_nxt  = 5'd16;
          cmd_pend_nxt = 1'b1;
          state_nxt    = DONE;
        end else if (ss_rise) begin
          frame_err_nxt = (bit_cnt != 5'd0) || sclk_rise;
          bit_cnt_nxt   = 5'd0;
          state_nxt     = IDLE;
        end else if (sclk_rise) begin
          rx_nxt      = {rx_shift[12:0], mosi_sync};
          bit_cnt_nxt = bit_cnt + 5'd1;
        end else if (sclk_fall && bit_cnt != 5'd0) begin
          // The falling edge ahead of the first rising edge leaves bit 15 in place
          tx_nxt = {tx_shift[14:0], 1'b0};
        end
      end

      DONE: begin
        if (cmd_pend) begin
          cur_ch_nxt   = rx_shift[13:11];
          cmd_vld_nxt  = 1'b1;
          cmd_pend_nxt = 1'b0;
        end else if (ss_sync) begin
          bit_cnt_nxt = 5'd0;
          state_nxt   = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= 5'd0;
      tx_shift  <= 16'd0;
      rx_shift  <= 14'd0;
      cur_ch    <= 3'd0;
      cmd_pend  <= 1'b0;
      cmd_vld   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      tx_shift  <= tx_nxt;
      rx_shift  <= rx_nxt;
      cur_ch    <= cur_ch_nxt;
      cmd_pend  <= cmd_pend_nxt;
      cmd_vld   <= cmd_vld_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  assign spi.MISO = (state == SHIFT && !ss_sync) ? tx_shift[15] : 1'b0;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb/tb_a2d_spi_resp.sv - directed self-checking bench for the A2D SPI responder
module tb_a2d_spi_resp;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;
  localparam int HALF   = 8;

  logic clk;
  logic rst_n;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [2:0] cur_ch;
  logic cmd_vld;
  logic frame_err;

  a2d_spi_resp_if spi ();

  a2d_spi_resp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi),
    .ch_data   (ch_data),
    .cur_ch    (cur_ch),
    .cmd_vld   (cmd_vld),
    .frame_err (frame_err)
  );

  int n_chk;
  int n_bad;
  int cmd_cnt;
  int err_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (cmd_vld)   cmd_cnt <= cmd_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK cycle: fall, drive MOSI, sample MISO just before the rise
  task automatic spi_bit(input logic b, output logic m);
    spi.SCLK = 1'b0;
    spi.MOSI = b;
    wait_clk(HALF);
    m = spi.MISO;
    spi.SCLK = 1'b1;
    wait_clk(HALF);
  endtask

  // Frame of nrise SCLK cycles; bits beyond 16 send 0; MISO bits collected MSB first
  task automatic spi_frame(input logic [15:0] mosi, input int nrise, output logic [31:0] miso);
    logic m;
    logic b;
    miso = '0;
    spi.SS_n = 1'b0;
    wait_clk(HALF);
    for (int k = 0; k < nrise; k++) begin
      b = (k < 16) ? mosi[15-k] : 1'b0;
      spi_bit(b, m);
      miso = {miso[30:0], m};
    end
    wait_clk(HALF);
    spi.SS_n = 1'b1;
    spi.MOSI = 1'b0;
    wait_clk(2*HALF);
  endtask

  initial begin
    logic [31:0] rd;
    logic        m;
    int          c0;
    int          e0;

    n_chk   = 0;
    n_bad   = 0;
    cmd_cnt = 0;
    err_cnt = 0;
    rst_n    = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    spi.MOSI = 1'b0;
    ch_data  = '0;
    ch_data[0*DATA_W +: DATA_W] = 12'h3A5;
    ch_data[2*DATA_W +: DATA_W] = 12'h111;
    ch_data[3*DATA_W +: DATA_W] = 12'h456;
    ch_data[5*DATA_W +: DATA_W] = 12'hFFF;
    ch_data[6*DATA_W +: DATA_W] = 12'hABC;
    wait_clk(4);

    chk("rst_miso",      32'(spi.MISO),  32'h0);
    chk("rst_cur_ch",    32'(cur_ch),    32'h0);
    chk("rst_cmd_vld",   32'(cmd_vld),   32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_clk(4);

    // Basic frame from channel 0
    c0 = cmd_cnt; e0 = err_cnt;
    spi_frame(16'h0000, 16, rd);
    chk("f0_miso",   rd,                   32'h03A5);
    chk("f0_cmd",    32'(cmd_cnt - c0),    32'd1);
    chk("f0_err",    32'(err_cnt - e0),    32'd0);
    chk("f0_cur_ch", 32'(cur_ch),          32'h0);

    // Address pipelining: frame N selects data for frame N+1
    spi_frame(16'h2800, 16, rd);
    chk("a5_miso",   rd,           32'h03A5);
    chk("a5_cur_ch", 32'(cur_ch),  32'h5);
    spi_frame(16'h0000, 16, rd);
    chk("a5_next",   rd,           32'h0FFF);
    chk("a0_cur_ch", 32'(cur_ch),  32'h0);

    // Short frame: error pulse, channel kept
    spi_frame(16'h2800, 16, rd);
    c0 = cmd_cnt; e0 = err_cnt;
    spi_frame(16'h1800, 7, rd);
    chk("short_err",    32'(err_cnt - e0), 32'd1);
    chk("short_cmd",    32'(cmd_cnt - c0), 32'd0);
    chk("short_cur_ch", 32'(cur_ch),       32'h5);
    spi_frame(16'h1000, 16, rd);
    chk("short_next",   rd,                32'h0FFF);
    chk("a2_cur_ch",    32'(cur_ch),       32'h2);

    // Snapshot: mid-frame change of ch2 must not leak into this frame
    fork
      spi_frame(16'h0000, 16, rd);
      begin
        wait_clk(HALF + 6*2*HALF);
        ch_data[2*DATA_W +: DATA_W] = 12'h222;
      end
    join
    chk("snap_old", rd, 32'h0111);
    spi_frame(16'h1000, 16, rd);
    chk("snap_cur0", rd, 32'h03A5);
    spi_frame(16'h0000, 16, rd);
    chk("snap_new", rd, 32'h0222);

    // Over-long frame: single cmd_vld, trailing MISO bits zero, no error
    c0 = cmd_cnt; e0 = err_cnt;
    spi_frame(16'h0000, 20, rd);
    chk("long_data",  rd[19:4],            32'h03A5);
    chk("long_tail",  32'(rd[3:0]),        32'h0);
    chk("long_cmd",   32'(cmd_cnt - c0),   32'd1);
    chk("long_err",   32'(err_cnt - e0),   32'd0);

    // Reset mid-frame at bit 9 of a frame addressed to ch6
    spi_frame(16'h3000, 16, rd);
    chk("a6_cur_ch", 32'(cur_ch), 32'h6);
    c0 = cmd_cnt; e0 = err_cnt;
    spi.SS_n = 1'b0;
    wait_clk(HALF);
    for (int k = 0; k < 9; k++) begin
      logic [15:0] w;
      w = 16'h3000;
      spi_bit(w[15-k], m);
    end
    rst_n    = 1'b0;
    spi.SS_n = 1'b1;
    spi.MOSI = 1'b0;
    wait_clk(4);
    chk("mrst_miso",   32'(spi.MISO),  32'h0);
    chk("mrst_cur_ch", 32'(cur_ch),    32'h0);
    chk("mrst_cmd",    32'(cmd_vld),   32'h0);
    chk("mrst_err",    32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_clk(2*HALF);
    chk("mrst_no_cmd", 32'(cmd_cnt - c0), 32'd0);
    chk("mrst_no_err", 32'(err_cnt - e0), 32'd0);
    spi_frame(16'h0000, 16, rd);
    chk("mrst_next", rd, 32'h03A5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
